// File: rtl/blowfish128_pkg.sv
// Shared types and widths for the Blowfish-128 job scheduler.
package blowfish128_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam int BF_BLOCK_W   = 128;
    localparam int BF_KEY_W     = 448;
    localparam int BF_KEY_WORDS = 7;
    localparam int BF_KLEN_W    = 4;

endpackage

// File: rtl/blowfish128_rr_arb.sv
// Combinational round-robin picker: first requesting index at or after i_ptr, wrapping.
module blowfish128_rr_arb
    import blowfish128_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    int w_best;
    int w_dist;

    // Smallest wrapped distance from the pointer wins.
    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_best = NUM_REQ;
        w_dist = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (j >= int'(i_ptr)) begin
                w_dist = j - int'(i_ptr);
            end else begin
                w_dist = j + NUM_REQ - int'(i_ptr);
            end
            if (i_req[j] && (w_dist < w_best)) begin
                w_best = w_dist;
                o_idx  = ID_W'(j);
            end
        end
        if (w_best < NUM_REQ) begin
            o_any        = 1'b1;
            o_gnt[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/blowfish128_sched.sv
// Round-robin job scheduler in front of a single blowfish128_top engine;
// owns the key registers and sequences the Enable/cipherReady handshake.
module blowfish128_sched
    import blowfish128_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int TIMEOUT = 4096
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_encrypt,
    input  logic [NUM_REQ*BF_BLOCK_W-1:0] req_data,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [BF_BLOCK_W-1:0]         rsp_data,
    output logic                          rsp_error,
    input  logic                          cfg_key_wr,
    input  logic [BF_KEY_W-1:0]           cfg_key,
    input  logic [BF_KLEN_W-1:0]          cfg_key_length,
    output logic                          cfg_key_ack,
    output logic                          busy,
    output logic                          eng_enable,
    output logic                          eng_encrypt,
    output logic [BF_BLOCK_W-1:0]         eng_plaintext,
    output logic [BF_KEY_W-1:0]           eng_key,
    output logic [BF_KLEN_W-1:0]          eng_key_length,
    input  logic [BF_BLOCK_W-1:0]         eng_ciphertext,
    input  logic                          eng_ready
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t                 r_state;
    logic [ID_W-1:0]        r_ptr;
    logic [BF_KEY_W-1:0]    r_key;
    logic [BF_KLEN_W-1:0]   r_klen;
    logic                   r_key_ack;
    logic [BF_BLOCK_W-1:0]  r_plain;
    logic                   r_enc;
    logic [ID_W-1:0]        r_id;
    logic [CNT_W-1:0]       r_cnt;
    logic [BF_BLOCK_W-1:0]  r_rsp_data;
    logic                   r_rsp_error;

    logic [NUM_REQ-1:0]     w_gnt;
    logic [ID_W-1:0]        w_idx;
    logic                   w_any;
    logic                   w_grant_ok;
    logic [BF_BLOCK_W-1:0]  w_sel_data;
    logic                   w_sel_enc;

    blowfish128_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // A key write in IDLE takes the cycle; no grant alongside it.
    assign w_grant_ok = (r_state == IDLE) && !Rst && !cfg_key_wr;
    assign req_ready  = w_grant_ok ? w_gnt : '0;
    assign w_sel_data = req_data[int'(w_idx)*BF_BLOCK_W +: BF_BLOCK_W];
    assign w_sel_enc  = req_encrypt[w_idx];

    assign busy           = (r_state != IDLE);
    assign eng_enable     = (r_state == RUN);
    assign eng_encrypt    = r_enc;
    assign eng_plaintext  = r_plain;
    assign eng_key        = r_key;
    assign eng_key_length = r_klen;
    assign cfg_key_ack    = r_key_ack;
    assign rsp_valid      = (r_state == RESP);
    assign rsp_id         = r_id;
    assign rsp_data       = r_rsp_data;
    assign rsp_error      = r_rsp_error;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_key       <= '0;
            r_klen      <= '0;
            r_key_ack   <= 1'b0;
            r_plain     <= '0;
            r_enc       <= 1'b0;
            r_id        <= '0;
            r_cnt       <= '0;
            r_rsp_data  <= '0;
            r_rsp_error <= 1'b0;
        end else begin
            r_key_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cfg_key_wr) begin
                        r_key     <= cfg_key;
                        r_klen    <= cfg_key_length;
                        r_key_ack <= 1'b1;
                    end else if (w_any) begin
                        r_plain <= w_sel_data;
                        r_enc   <= w_sel_enc;
                        r_id    <= w_idx;
                        r_ptr   <= (w_idx == ID_W'(NUM_REQ-1)) ? '0 : w_idx + 1'b1;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    // A ready on the final allowed cycle still counts as success.
                    if (eng_ready) begin
                        r_rsp_data  <= eng_ciphertext;
                        r_rsp_error <= 1'b0;
                        r_state     <= RESP;
                    end else if (r_cnt == CNT_W'(TIMEOUT-1)) begin
                        r_rsp_data  <= '0;
                        r_rsp_error <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state <= GAP;
                    end
                end
                GAP: begin
                    r_rsp_error <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blowfish128_sched.sv
// Directed bench for blowfish128_sched with a 5-cycle inverting engine stub.
module tb_blowfish128_sched;

    logic         Clk = 1'b0;
    logic         Rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [3:0]   req_encrypt;
    logic [511:0] req_data;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [127:0] rsp_data;
    logic         rsp_error;
    logic         cfg_key_wr;
    logic [447:0] cfg_key;
    logic [3:0]   cfg_key_length;
    logic         cfg_key_ack;
    logic         busy;
    logic         eng_enable;
    logic         eng_encrypt;
    logic [127:0] eng_plaintext;
    logic [447:0] eng_key;
    logic [3:0]   eng_key_length;
    logic [127:0] eng_ciphertext;
    logic         eng_ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [447:0] KEY;
    logic [3:0]   ENC_V;
    logic [127:0] blk [4];

    logic hang;
    int   stub_cnt;
    logic stub_rdy;

    always #5 Clk = ~Clk;

    blowfish128_sched #(
        .NUM_REQ (4),
        .ID_W    (2),
        .TIMEOUT (16)
    ) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_encrypt    (req_encrypt),
        .req_data       (req_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_data       (rsp_data),
        .rsp_error      (rsp_error),
        .cfg_key_wr     (cfg_key_wr),
        .cfg_key        (cfg_key),
        .cfg_key_length (cfg_key_length),
        .cfg_key_ack    (cfg_key_ack),
        .busy           (busy),
        .eng_enable     (eng_enable),
        .eng_encrypt    (eng_encrypt),
        .eng_plaintext  (eng_plaintext),
        .eng_key        (eng_key),
        .eng_key_length (eng_key_length),
        .eng_ciphertext (eng_ciphertext),
        .eng_ready      (eng_ready)
    );

    // Engine stub: ready 5 cycles after Enable rises, result is the inverted block.
    always @(posedge Clk) begin
        if (!eng_enable) begin
            stub_cnt <= 0;
            stub_rdy <= 1'b0;
        end else begin
            stub_cnt <= stub_cnt + 1;
            stub_rdy <= (stub_cnt == 4) && !hang;
        end
    end
    assign eng_ready      = stub_rdy;
    assign eng_ciphertext = ~eng_plaintext;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic job(input logic [3:0] vld, input logic [3:0] hold, input logic [3:0] exp_gnt,
                       input logic [1:0] exp_id, input logic exp_err, input int exp_lat,
                       input int stall, input string tag);
        int n;
        logic [127:0] exp_rsp;
        exp_rsp = exp_err ? 128'd0 : ~blk[exp_id];
        req_valid = vld;
        #1;
        chk({tag, ".gnt"}, 512'(req_ready), 512'(exp_gnt));
        n = 0;
        do begin
            @(negedge Clk);
            n++;
            if (n == 1) begin
                req_valid = hold;
                chk({tag, ".en"}, 512'(eng_enable), 512'(1'b1));
                chk({tag, ".pt"}, 512'(eng_plaintext), 512'(blk[exp_id]));
                chk({tag, ".enc"}, 512'(eng_encrypt), 512'(ENC_V[exp_id]));
                chk({tag, ".ack0"}, 512'(cfg_key_ack), 512'(1'b0));
                chk({tag, ".busy"}, 512'(busy), 512'(1'b1));
            end
        end while (!rsp_valid && n < 64);
        chk({tag, ".lat"}, 512'(n), 512'(exp_lat));
        chk({tag, ".id"}, 512'(rsp_id), 512'(exp_id));
        chk({tag, ".data"}, 512'(rsp_data), 512'(exp_rsp));
        chk({tag, ".err"}, 512'(rsp_error), 512'(exp_err));
        chk({tag, ".en_off"}, 512'(eng_enable), 512'(1'b0));
        for (int s = 0; s < stall; s++) begin
            cfg_key_wr = 1'b1;
            cfg_key    = ~KEY;
            req_valid  = 4'hF;
            #1;
            chk({tag, ".stall_rdy"}, 512'(req_ready), 512'(4'h0));
            chk({tag, ".stall_vld"}, 512'(rsp_valid), 512'(1'b1));
            chk({tag, ".stall_data"}, 512'(rsp_data), 512'(exp_rsp));
            @(negedge Clk);
            chk({tag, ".stall_ack"}, 512'(cfg_key_ack), 512'(1'b0));
        end
        if (stall > 0) begin
            cfg_key_wr = 1'b0;
            cfg_key    = KEY;
            req_valid  = hold;
            chk({tag, ".key_kept"}, 512'(eng_key), 512'(KEY));
        end
        rsp_ready = 1'b1;
        @(negedge Clk);
        rsp_ready = 1'b0;
        chk({tag, ".gap_vld"}, 512'(rsp_valid), 512'(1'b0));
        chk({tag, ".gap_busy"}, 512'(busy), 512'(1'b1));
        chk({tag, ".gap_en"}, 512'(eng_enable), 512'(1'b0));
        @(negedge Clk);
        chk({tag, ".idle"}, 512'(busy), 512'(1'b0));
        chk({tag, ".err_clr"}, 512'(rsp_error), 512'(1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int cnt;
        KEY    = {64'h7, 64'h6, 64'h5, 64'h4, 64'h3, 64'h2, 64'h1};
        ENC_V  = 4'b0101;
        blk[0] = 128'h0123456789ABCDEF0123456789ABCDEF;
        blk[1] = 128'hDEADBEEF00112233445566778899AABB;
        blk[2] = 128'hA5A5A5A55A5A5A5AFFFF0000C3C3C3C3;
        blk[3] = 128'h13579BDF2468ACE00F1E2D3C4B5A6978;
        Rst            = 1'b1;
        req_valid      = 4'h0;
        req_encrypt    = ENC_V;
        req_data       = {blk[3], blk[2], blk[1], blk[0]};
        rsp_ready      = 1'b0;
        cfg_key_wr     = 1'b0;
        cfg_key        = '0;
        cfg_key_length = 4'd0;
        hang           = 1'b0;

        repeat (3) @(negedge Clk);
        chk("rst.ready", 512'(req_ready), 512'(4'h0));
        chk("rst.rsp_valid", 512'(rsp_valid), 512'(1'b0));
        chk("rst.rsp_id", 512'(rsp_id), 512'(2'd0));
        chk("rst.rsp_data", 512'(rsp_data), 512'(128'd0));
        chk("rst.rsp_error", 512'(rsp_error), 512'(1'b0));
        chk("rst.ack", 512'(cfg_key_ack), 512'(1'b0));
        chk("rst.busy", 512'(busy), 512'(1'b0));
        chk("rst.en", 512'(eng_enable), 512'(1'b0));
        chk("rst.key", 512'(eng_key), 512'(448'd0));
        chk("rst.klen", 512'(eng_key_length), 512'(4'd0));
        Rst = 1'b0;
        @(negedge Clk);

        // key write wins over a pending request
        cfg_key_wr     = 1'b1;
        cfg_key        = KEY;
        cfg_key_length = 4'd7;
        req_valid      = 4'b0001;
        #1;
        chk("t1.no_gnt", 512'(req_ready), 512'(4'h0));
        @(negedge Clk);
        cfg_key_wr = 1'b0;
        chk("t1.ack", 512'(cfg_key_ack), 512'(1'b1));
        chk("t1.key", 512'(eng_key), 512'(KEY));
        chk("t1.klen", 512'(eng_key_length), 512'(4'd7));
        chk("t1.busy", 512'(busy), 512'(1'b0));

        job(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0, 7, 0, "t2");
        job(4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b0, 7, 10, "t5");
        hang = 1'b1;
        job(4'b1001, 4'b0000, 4'b1000, 2'd3, 1'b1, 17, 0, "t4");
        hang = 1'b0;

        // reset in the middle of a job
        req_valid = 4'b0100;
        #1;
        chk("t6.gnt", 512'(req_ready), 512'(4'b0100));
        @(negedge Clk);
        req_valid = 4'b0000;
        chk("t6.en", 512'(eng_enable), 512'(1'b1));
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        chk("t6.en_off", 512'(eng_enable), 512'(1'b0));
        chk("t6.busy", 512'(busy), 512'(1'b0));
        chk("t6.key_clr", 512'(eng_key), 512'(448'd0));
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            if (rsp_valid) cnt++;
        end
        chk("t6.no_rsp", 512'(cnt), 512'(0));

        // all requesters continuously valid: order must restart at 0 after reset
        job(4'hF, 4'hF, 4'b0001, 2'd0, 1'b0, 7, 0, "t3a");
        job(4'hF, 4'hF, 4'b0010, 2'd1, 1'b0, 7, 0, "t3b");
        job(4'hF, 4'hF, 4'b0100, 2'd2, 1'b0, 7, 0, "t3c");
        job(4'hF, 4'hF, 4'b1000, 2'd3, 1'b0, 7, 0, "t3d");
        job(4'hF, 4'h0, 4'b0001, 2'd0, 1'b0, 7, 0, "t3e");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
